// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
// Holds the op encoding, FSM states and the step-counter width helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add or restoring shift-subtract.
// Ports: acc/sr/opnd state in, div selects divide, acc_n/sr_n next state out.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] opnd,
    input  logic             div,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] sr_n
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : '0);
        rem_sh = {acc, sr[WIDTH-1]};
        ge     = rem_sh >= {1'b0, opnd};
        // Partial remainder stays below the divisor, so the low bits suffice.
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (div) begin
            acc_n = ge ? diff : rem_sh[WIDTH-1:0];
            sr_n  = {sr[WIDTH-2:0], ge};
        end else begin
            acc_n = sum[WIDTH:1];
            sr_n  = {sum[0], sr[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, WIDTH+1 cycle latency.
// Ports: clk, reset, start/op/srca/srcb, hiwrite/lowrite/wd -> busy, done, divzero, hi, lo.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiwrite,
    input  logic             lowrite,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_w(WIDTH);
`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    op_e                op_c;
    logic [WIDTH-1:0]   acc_q, sr_q, opnd_q;
    logic [WIDTH-1:0]   acc_n, sr_n;
    logic [CW-1:0]      cnt_q;
    logic               div_q, neg_q_q, neg_r_q;
    logic               sgn, sa, sb, last, dz;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_c;
    logic [WIDTH-1:0]   q_c, r_c, res_hi, res_lo;

    assign op_c  = op_e'(op);
    assign sgn   = SGN_EN && (op_c == MULT || op_c == DIV);
    assign sa    = sgn & srca[WIDTH-1];
    assign sb    = sgn & srcb[WIDTH-1];
    assign mag_a = sa ? -srca : srca;
    assign mag_b = sb ? -srcb : srcb;
    assign last  = (cnt_q == CW'(WIDTH - 1));
    assign busy  = (state_q != IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc   (acc_q),
        .sr    (sr_q),
        .opnd  (opnd_q),
        .div   (div_q),
        .acc_n (acc_n),
        .sr_n  (sr_n)
    );

    // Divide by zero leaves |srca| as remainder; re-signing it restores srca.
    // Overflow (most-negative / -1) falls out of the magnitude path naturally.
    always_comb begin
        dz     = div_q && (opnd_q == '0);
        prod   = {acc_q, sr_q};
        prod_c = neg_q_q ? -prod : prod;
        q_c    = dz ? '1 : (neg_q_q ? -sr_q : sr_q);
        r_c    = neg_r_q ? -acc_q : acc_q;
        res_hi = div_q ? r_c : prod_c[2*WIDTH-1:WIDTH];
        res_lo = div_q ? q_c : prod_c[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            sr_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        sr_q    <= mag_a;
                        opnd_q  <= mag_b;
                        cnt_q   <= '0;
                        div_q   <= op[1];
                        neg_q_q <= sa ^ sb;
                        neg_r_q <= sa;
                    end else begin
                        if (hiwrite) hi <= wd;
                        if (lowrite) lo <= wd;
                    end
                end
                RUN: begin
                    acc_q <= acc_n;
                    sr_q  <= sr_n;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIN: begin
                    hi      <= res_hi;
                    lo      <= res_lo;
                    done    <= 1'b1;
                    divzero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule
